mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port, word-organised unified memory between the rv32i_cpu instruction-fetch port and its load/store port. It grants at most one access per cycle and alternates on contention so neither port starves. It tracks which port owns the one-cycle-latency read return and routes the response back to that port. It sits between the CPU core and the memory model.

## Interface
- ADDR_WIDTH, 32, byte-address width on all ports
- DATA_WIDTH, 32, data width; byte strobes are DATA_WIDTH/8 bits
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- i_req  input  1  fetch request (read only)
- i_addr  input  ADDR_WIDTH  fetch byte address
- i_gnt  output  1  fetch accepted this cycle (combinational)
- i_rvalid  output  1  fetch data valid (registered)
- i_rdata  output  DATA_WIDTH  fetch data
- d_req  input  1  data request
- d_we  input  1  1 = store, 0 = load
- d_be  input  DATA_WIDTH/8  store byte enables
- d_addr  input  ADDR_WIDTH  data byte address
- d_wdata  input  DATA_WIDTH  store data
- d_gnt  output  1  data accepted this cycle (combinational)
- d_rvalid  output  1  load data / store ack (registered)
- d_rdata  output  DATA_WIDTH  load data
- mem_req, mem_we  output  1 each  memory access strobe and write enable
- mem_be  output  DATA_WIDTH/8  memory byte enables
- mem_addr  output  ADDR_WIDTH  word-aligned byte address {addr[ADDR_WIDTH-1:2], 2'b00}
- mem_wdata  output  DATA_WIDTH  store data to memory
- mem_rdata  input  DATA_WIDTH  read data, valid the cycle after mem_req

## Operation
- Response state: RESP_NONE, RESP_I, RESP_D (which port receives the response this cycle); plus last_owner register (I or D) and resp_we register.
- Grant per cycle, combinational: only i_req -> I; only d_req -> D; both -> the port that is not last_owner; neither -> no grant.
- Grant I: mem_req=1, mem_we=0, mem_be=all ones, mem_addr from i_addr; next response state RESP_I, last_owner<=I.
- Grant D: mem_req=1, mem_we=d_we, mem_be=d_we ? d_be : all ones, mem_addr from d_addr, mem_wdata=d_wdata; next RESP_D, resp_we<=d_we, last_owner<=D.
- No grant: mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0; next RESP_NONE.
- RESP_I: i_rvalid=1, i_rdata=mem_rdata. RESP_D: d_rvalid=1; d_rdata=mem_rdata for loads, 0 for store acks.
- rdata outputs are 0 whenever the matching rvalid is 0.
- Grants are independent of response state: back-to-back grants allowed, one access and one response per cycle, full throughput.
- Requester holds req/addr/data stable until gnt; deasserting req before gnt is legal and drops the request.
- Addresses low two bits ignored; misaligned accesses are not flagged.

## Timing
- Reset (asynchronous, immediate): response state RESP_NONE, last_owner=D (fetch wins first tie), resp_we=0; i_rvalid=d_rvalid=0, rdata outputs 0. gnt and mem_* outputs follow the combinational rules from inputs (no grant while reset is high: gnt=0, mem_req=0).
- Reset mid-transaction: a response due next cycle is discarded; no rvalid after reset release without a new grant.
- Latency: request in cycle N with grant -> rvalid in cycle N+1. Denied request waits at most one cycle when the other port requests continuously.
- Simultaneous grant and response: cycle N+1 may assert rvalid to one port and gnt to either port.
- Store in cycle N followed by a load of the same word in N+1 returns the new data (memory writes on the edge ending cycle N).

## Test plan
- Reset release, i_req=1 i_addr=0x0 only -> i_gnt=1 same cycle, mem_addr=0x0; next cycle i_rvalid=1, i_rdata=memory[0]=0x00000093.
- Both requesting every cycle for 6 cycles -> grants I,D,I,D,I,D; each rvalid one cycle after its grant; no gaps in mem_req.
- Store d_we=1 d_be=4'b0011 d_addr=0x10 d_wdata=0xAABBCCDD over 0x11223344, then load 0x10 -> d_rvalid ack with d_rdata=0, then d_rdata=0x1122CCDD.
- d_addr=0x13 load -> mem_addr=0x10, returns word at 0x10.
- Grant at cycle N, reset pulsed at N+0.5 -> i_rvalid and d_rvalid stay 0 through N+2; first tie afterwards granted to I.
- Idle (no requests) -> mem_req=0, mem_be=0, both rvalid 0 every cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Shared fetch/load-store/memory bus seen by the arbiter. The master side is the
// CPU core plus memory model; the slave side is the arbiter itself.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                    i_req;
  logic [ADDR_WIDTH-1:0]   i_addr;
  logic                    i_gnt;
  logic                    i_rvalid;
  logic [DATA_WIDTH-1:0]   i_rdata;

  logic                    d_req;
  logic                    d_we;
  logic [DATA_WIDTH/8-1:0] d_be;
  logic [ADDR_WIDTH-1:0]   d_addr;
  logic [DATA_WIDTH-1:0]   d_wdata;
  logic                    d_gnt;
  logic                    d_rvalid;
  logic [DATA_WIDTH-1:0]   d_rdata;

  logic                    mem_req;
  logic                    mem_we;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port word memory between the fetch and load/store ports,
// alternating on contention and routing the one-cycle-late read data back.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam int BE_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_I    = 2'd1,
    RESP_D    = 2'd2
  } resp_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  resp_e  resp_q, resp_d;
  owner_e last_owner_q, last_owner_d;
  logic   resp_we_q, resp_we_d;
  logic   grant_i, grant_d;

  // On a tie the port that did not win last time gets the memory.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!reset) begin
      if (bus.i_req && bus.d_req) begin
        grant_i = (last_owner_q == OWN_D);
        grant_d = (last_owner_q == OWN_I);
      end else begin
        grant_i = bus.i_req;
        grant_d = bus.d_req;
      end
    end
  end

  always_comb begin
    resp_d       = RESP_NONE;
    last_owner_d = last_owner_q;
    resp_we_d    = resp_we_q;
    if (grant_i) begin
      resp_d       = RESP_I;
      last_owner_d = OWN_I;
    end else if (grant_d) begin
      resp_d       = RESP_D;
      resp_we_d    = bus.d_we;
      last_owner_d = OWN_D;
    end
  end

  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (grant_i) begin
      bus.mem_req  = 1'b1;
      bus.mem_be   = {BE_W{1'b1}};
      bus.mem_addr = {bus.i_addr[ADDR_WIDTH-1:2], 2'b00};
    end else if (grant_d) begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = bus.d_we;
      bus.mem_be    = bus.d_we ? bus.d_be : {BE_W{1'b1}};
      bus.mem_addr  = {bus.d_addr[ADDR_WIDTH-1:2], 2'b00};
      bus.mem_wdata = bus.d_wdata;
    end
  end

  // Reset drops any response already in flight; fetch wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_q       <= RESP_NONE;
      last_owner_q <= OWN_D;
      resp_we_q    <= 1'b0;
    end else begin
      resp_q       <= resp_d;
      last_owner_q <= last_owner_d;
      resp_we_q    <= resp_we_d;
    end
  end

  assign bus.i_gnt    = grant_i;
  assign bus.d_gnt    = grant_d;
  assign bus.i_rvalid = (resp_q == RESP_I);
  assign bus.d_rvalid = (resp_q == RESP_D);
  assign bus.i_rdata  = (resp_q == RESP_I) ? bus.mem_rdata : '0;
  // Store acknowledgements carry no data.
  assign bus.d_rdata  = (resp_q == RESP_D && !resp_we_q) ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small registered-read word memory model.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: contents loaded once, writes and reads on the rising edge.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0100_0000 | i;
    mem[0] = 32'h0000_0093;
    mem[1] = 32'h0010_0113;
    mem[4] = 32'h1122_3344;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.mem_req) begin
        if (bus.mem_we) begin
          for (int b = 0; b < 4; b++)
            if (bus.mem_be[b]) mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end else begin
          bus.mem_rdata <= mem[bus.mem_addr[7:2]];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_be    = '0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  initial begin
    logic exp_i;
    reset = 1'b1;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1;

    // Reset held: no grant even with a request, no responses.
    bus.i_req = 1'b1;
    #2;
    check("rst_i_gnt", 32'(bus.i_gnt), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_i_rvalid", 32'(bus.i_rvalid), 32'd0);
    check("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    check("rst_i_rdata", bus.i_rdata, 32'd0);
    check("rst_d_rdata", bus.d_rdata, 32'd0);

    // First fetch after release.
    next_cycle();
    reset = 1'b0;
    #2;
    check("f0_i_gnt", 32'(bus.i_gnt), 32'd1);
    check("f0_d_gnt", 32'(bus.d_gnt), 32'd0);
    check("f0_mem_addr", bus.mem_addr, 32'h0);
    check("f0_mem_be", 32'(bus.mem_be), 32'hF);
    check("f0_mem_we", 32'(bus.mem_we), 32'd0);
    next_cycle();
    bus.i_req = 1'b0;
    #2;
    check("f0_i_rvalid", 32'(bus.i_rvalid), 32'd1);
    check("f0_i_rdata", bus.i_rdata, 32'h0000_0093);
    check("f0_d_rvalid", 32'(bus.d_rvalid), 32'd0);

    // A lone data load makes D the last owner, so the following tie starts with I.
    next_cycle();
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h10;
    #2;
    check("ld_d_gnt", 32'(bus.d_gnt), 32'd1);
    check("ld_mem_addr", bus.mem_addr, 32'h10);

    next_cycle();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h4;
    for (int k = 0; k < 6; k++) begin
      #2;
      exp_i = (k % 2 == 0);
      check($sformatf("tie%0d_i_gnt", k), 32'(bus.i_gnt), 32'(exp_i));
      check($sformatf("tie%0d_d_gnt", k), 32'(bus.d_gnt), 32'(!exp_i));
      check($sformatf("tie%0d_mem_req", k), 32'(bus.mem_req), 32'd1);
      check($sformatf("tie%0d_i_rvalid", k), 32'(bus.i_rvalid), 32'(!exp_i));
      check($sformatf("tie%0d_d_rvalid", k), 32'(bus.d_rvalid), 32'(exp_i));
      check($sformatf("tie%0d_i_rdata", k), bus.i_rdata, exp_i ? 32'h0 : 32'h0010_0113);
      check($sformatf("tie%0d_d_rdata", k), bus.d_rdata, exp_i ? 32'h1122_3344 : 32'h0);
      next_cycle();
    end
    clear_reqs();
    #2;
    check("tie_end_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    check("tie_end_i_rvalid", 32'(bus.i_rvalid), 32'd0);
    check("tie_end_d_rdata", bus.d_rdata, 32'h1122_3344);

    // Partial store, then a misaligned load of the same word right behind it.
    next_cycle();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_be    = 4'b0011;
    bus.d_addr  = 32'h10;
    bus.d_wdata = 32'hAABB_CCDD;
    #2;
    check("st_d_gnt", 32'(bus.d_gnt), 32'd1);
    check("st_mem_we", 32'(bus.mem_we), 32'd1);
    check("st_mem_be", 32'(bus.mem_be), 32'h3);
    check("st_mem_wdata", bus.mem_wdata, 32'hAABB_CCDD);
    next_cycle();
    bus.d_we   = 1'b0;
    bus.d_be   = '0;
    bus.d_addr = 32'h13;
    #2;
    check("st_ack_rvalid", 32'(bus.d_rvalid), 32'd1);
    check("st_ack_rdata", bus.d_rdata, 32'h0);
    check("ld13_d_gnt", 32'(bus.d_gnt), 32'd1);
    check("ld13_mem_addr", bus.mem_addr, 32'h10);
    check("ld13_mem_be", 32'(bus.mem_be), 32'hF);
    check("ld13_mem_we", 32'(bus.mem_we), 32'd0);
    next_cycle();
    clear_reqs();
    #2;
    check("ld13_rvalid", 32'(bus.d_rvalid), 32'd1);
    check("ld13_rdata", bus.d_rdata, 32'h1122_CCDD);

    // Reset pulse between a grant and its response discards the response.
    next_cycle();
    bus.i_req = 1'b1;
    #2;
    check("mid_i_gnt", 32'(bus.i_gnt), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_i_gnt", 32'(bus.i_gnt), 32'd0);
    check("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
    bus.i_req = 1'b0;
    #1;
    reset = 1'b0;
    next_cycle();
    #2;
    check("mid_n1_i_rvalid", 32'(bus.i_rvalid), 32'd0);
    check("mid_n1_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    check("mid_n1_i_rdata", bus.i_rdata, 32'd0);
    next_cycle();
    #2;
    check("mid_n2_i_rvalid", 32'(bus.i_rvalid), 32'd0);
    check("mid_n2_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    next_cycle();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0;
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h10;
    #2;
    check("post_rst_tie_i_gnt", 32'(bus.i_gnt), 32'd1);
    check("post_rst_tie_d_gnt", 32'(bus.d_gnt), 32'd0);
    next_cycle();
    clear_reqs();
    #2;
    check("post_rst_i_rvalid", 32'(bus.i_rvalid), 32'd1);
    check("post_rst_i_rdata", bus.i_rdata, 32'h0000_0093);

    // Idle cycles.
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      #2;
      check($sformatf("idle%0d_mem_req", k), 32'(bus.mem_req), 32'd0);
      check($sformatf("idle%0d_mem_be", k), 32'(bus.mem_be), 32'd0);
      check($sformatf("idle%0d_mem_addr", k), bus.mem_addr, 32'd0);
      check($sformatf("idle%0d_i_rvalid", k), 32'(bus.i_rvalid), 32'd0);
      check($sformatf("idle%0d_d_rvalid", k), 32'(bus.d_rvalid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
